// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls-and-Cows keypad front end.
package bc_pkg;

  typedef enum logic [1:0] {
    ENTRY       = 2'd0,
    WAIT_RESULT = 2'd1,
    WON         = 2'd2,
    LOST        = 2'd3
  } state_t;

  localparam logic [3:0] EMPTY_NIBBLE  = 4'hF;
  localparam int         KEY_CLEAR_IDX = 10;
  localparam int         KEY_ENTER_IDX = 11;
  localparam int         NUM_KEYS      = 12;
  localparam int         GUESS_W       = 16;

  // Index of the highest set bit; callers only rely on it for one-hot vectors.
  function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus one shared stability counter for a key vector;
// reports the accepted (stable) vector and its rising edges.
module key_debounce #(
  parameter int N               = 12,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] stable,
  output logic [N-1:0] rise
);

  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  last;
  logic [N-1:0]  stable_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= '0;
      sync2       <= '0;
      last        <= '0;
      stable      <= '0;
      stable_prev <= '0;
      cnt         <= '0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      last        <= sync2;
      stable_prev <= stable;
      // Any change of the whole vector restarts the shared window
      if (sync2 != last) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        stable <= last;
      end
    end
  end

  assign rise = stable & ~stable_prev;

endmodule

// File: rtl/guess_entry_ctrl.sv
// Keypad entry controller: builds a 4-digit guess without repeats, submits it
// on ENTER and tracks attempts and the game outcome.
module guess_entry_ctrl
  import bc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_ATTEMPTS    = 10,
  parameter int RESULT_LATENCY  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         key_digit,
  input  logic               key_clear,
  input  logic               key_enter,
  input  logic               is_four_strike,
  output logic [GUESS_W-1:0] guess,
  output logic               guess_valid,
  output logic [GUESS_W-1:0] entry_buf,
  output logic [2:0]         digit_count,
  output logic [3:0]         attempts,
  output logic               dup_err,
  output logic               game_won,
  output logic               game_over
);

  localparam int             WCW        = (RESULT_LATENCY > 0) ? $clog2(RESULT_LATENCY + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(RESULT_LATENCY);
  localparam logic [3:0]     ATT_LIMIT  = 4'(MAX_ATTEMPTS);
  localparam logic [GUESS_W-1:0] EMPTY_BUF = {4{EMPTY_NIBBLE}};

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] rise;

  assign raw_keys = {key_enter, key_clear, key_digit};

  key_debounce #(
    .N               (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw_keys),
    .stable (stable),
    .rise   (rise)
  );

  // Only a lone key counts; chords are dropped as a whole
  logic       key_event;
  logic [3:0] key_idx;
  logic       ev_digit;
  logic       ev_clear;
  logic       ev_enter;

  assign key_event = (rise != '0) && $onehot(stable);
  assign key_idx   = key_index(stable);
  assign ev_digit  = key_event && (key_idx <= 4'd9);
  assign ev_clear  = key_event && (key_idx == 4'(KEY_CLEAR_IDX));
  assign ev_enter  = key_event && (key_idx == 4'(KEY_ENTER_IDX));

  // Occupied nibbles sit at the low end; filler nibbles are never compared
  function automatic logic digit_present(input logic [GUESS_W-1:0] buf_v,
                                         input logic [2:0]         cnt,
                                         input logic [3:0]         d);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < cnt) && (buf_v[4*i +: 4] == d)) hit = 1'b1;
    end
    return hit;
  endfunction

  state_t             state;
  state_t             state_n;
  logic [GUESS_W-1:0] entry_buf_n;
  logic [2:0]         digit_count_n;
  logic [3:0]         attempts_n;
  logic [GUESS_W-1:0] guess_n;
  logic               guess_valid_n;
  logic               dup_err_n;
  logic [WCW-1:0]     wait_cnt;
  logic [WCW-1:0]     wait_cnt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ENTRY;
      entry_buf   <= EMPTY_BUF;
      digit_count <= 3'd0;
      attempts    <= 4'd0;
      guess       <= EMPTY_BUF;
      guess_valid <= 1'b0;
      dup_err     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      entry_buf   <= entry_buf_n;
      digit_count <= digit_count_n;
      attempts    <= attempts_n;
      guess       <= guess_n;
      guess_valid <= guess_valid_n;
      dup_err     <= dup_err_n;
      wait_cnt    <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    entry_buf_n   = entry_buf;
    digit_count_n = digit_count;
    attempts_n    = attempts;
    guess_n       = guess;
    guess_valid_n = 1'b0;
    dup_err_n     = 1'b0;
    wait_cnt_n    = wait_cnt;

    case (state)
      ENTRY: begin
        if (ev_digit) begin
          if (digit_count != 3'd4) begin
            if (digit_present(entry_buf, digit_count, key_idx)) begin
              dup_err_n = 1'b1;
            end else begin
              entry_buf_n   = {entry_buf[GUESS_W-5:0], key_idx};
              digit_count_n = digit_count + 3'd1;
            end
          end
        end else if (ev_clear) begin
          entry_buf_n   = EMPTY_BUF;
          digit_count_n = 3'd0;
        end else if (ev_enter && (digit_count == 3'd4)) begin
          guess_n       = entry_buf;
          guess_valid_n = 1'b1;
          attempts_n    = (attempts == 4'hF) ? attempts : attempts + 4'd1;
          wait_cnt_n    = '0;
          state_n       = WAIT_RESULT;
        end
      end

      // wait_cnt is 0 in the guess_valid cycle; the result is sampled when it
      // reaches the configured latency
      WAIT_RESULT: begin
        if (wait_cnt == WAIT_LAST) begin
          if (is_four_strike) begin
            state_n = WON;
          end else if (attempts == ATT_LIMIT) begin
            state_n = LOST;
          end else begin
            state_n       = ENTRY;
            entry_buf_n   = EMPTY_BUF;
            digit_count_n = 3'd0;
          end
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end

      WON, LOST: begin
        if (ev_clear) begin
          state_n       = ENTRY;
          attempts_n    = 4'd0;
          entry_buf_n   = EMPTY_BUF;
          digit_count_n = 3'd0;
        end
      end

      default: state_n = ENTRY;
    endcase
  end

  assign game_won  = (state == WON);
  assign game_over = (state == WON) || (state == LOST);

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Randomised self-checking bench for guess_entry_ctrl against a queue-based
// model of the game rules.
module tb_guess_entry_ctrl;

  localparam int DEB  = 4;
  localparam int MAXA = 10;
  localparam int RL   = 2;
  localparam int HOLD = DEB + 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  key_digit = '0;
  logic        key_clear = 1'b0;
  logic        key_enter = 1'b0;
  logic        is_four_strike = 1'b0;
  logic [15:0] guess;
  logic        guess_valid;
  logic [15:0] entry_buf;
  logic [2:0]  digit_count;
  logic [3:0]  attempts;
  logic        dup_err;
  logic        game_won;
  logic        game_over;

  guess_entry_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .MAX_ATTEMPTS    (MAXA),
    .RESULT_LATENCY  (RL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_digit      (key_digit),
    .key_clear      (key_clear),
    .key_enter      (key_enter),
    .is_four_strike (is_four_strike),
    .guess          (guess),
    .guess_valid    (guess_valid),
    .entry_buf      (entry_buf),
    .digit_count    (digit_count),
    .attempts       (attempts),
    .dup_err        (dup_err),
    .game_won       (game_won),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: game rules over a queue of entered digits
  typedef enum int {M_ENTRY, M_WON, M_LOST} mstate_e;
  int          mq[$];
  int          m_att   = 0;
  mstate_e     m_state = M_ENTRY;
  logic [15:0] m_guess = 16'hFFFF;
  int          exp_dup = 0;
  int          exp_gv  = 0;
  bit          win_next = 1'b0;

  int dup_seen  = 0;
  int gv_seen   = 0;
  int gv_double = 0;
  bit gv_prev   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (dup_err) dup_seen++;
      if (guess_valid) begin
        gv_seen++;
        if (gv_prev) gv_double++;
      end
      gv_prev = guess_valid;
    end
  end

  // Scoring stand-in: answers exactly RL cycles after each guess_valid
  initial begin
    forever begin
      @(negedge clk);
      if (guess_valid) begin
        repeat (RL) @(negedge clk);
        is_four_strike = win_next;
        @(negedge clk);
        is_four_strike = 1'b0;
      end
    end
  end

  function automatic logic [15:0] model_buf();
    logic [15:0] v;
    int n;
    v = 16'hFFFF;
    n = mq.size();
    for (int i = 0; i < n; i++) v[4*(n-1-i) +: 4] = 4'(mq[i]);
    return v;
  endfunction

  function automatic bit model_has(input int d);
    foreach (mq[i]) if (mq[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_key(input int idx);
    case (m_state)
      M_ENTRY: begin
        if (idx < 10) begin
          if (mq.size() < 4) begin
            if (model_has(idx)) exp_dup++;
            else mq.push_back(idx);
          end
        end else if (idx == 10) begin
          mq.delete();
        end else if (mq.size() == 4) begin
          m_guess = model_buf();
          exp_gv++;
          if (m_att < 15) m_att++;
          if (win_next) m_state = M_WON;
          else if (m_att == MAXA) m_state = M_LOST;
          else mq.delete();
        end
      end
      default: begin
        if (idx == 10) begin
          m_att = 0;
          mq.delete();
          m_state = M_ENTRY;
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".buf"},   32'(entry_buf),   32'(model_buf()));
    check_val({tag, ".cnt"},   32'(digit_count), 32'(mq.size()));
    check_val({tag, ".att"},   32'(attempts),    32'(m_att));
    check_val({tag, ".won"},   32'(game_won),    32'(m_state == M_WON));
    check_val({tag, ".over"},  32'(game_over),   32'(m_state != M_ENTRY));
    check_val({tag, ".guess"}, 32'(guess),       32'(m_guess));
    check_val({tag, ".dup"},   32'(dup_seen),    32'(exp_dup));
    check_val({tag, ".gv"},    32'(gv_seen),     32'(exp_gv));
  endtask

  task automatic drive_keys(input logic [11:0] v);
    {key_enter, key_clear, key_digit} = v;
  endtask

  task automatic press(input int idx);
    logic [11:0] v;
    v = 12'd1 << idx;
    @(negedge clk);
    drive_keys(v);
    repeat (HOLD) @(negedge clk);
    drive_keys('0);
    repeat (HOLD) @(negedge clk);
    model_key(idx);
    check_all($sformatf("k%0d", idx));
  endtask

  int r;
  int n;
  int idx;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.buf",   32'(entry_buf),   32'hFFFF);
    check_val("rst.guess", 32'(guess),       32'hFFFF);
    check_val("rst.cnt",   32'(digit_count), 32'd0);
    check_val("rst.att",   32'(attempts),    32'd0);
    check_val("rst.flags", 32'({guess_valid, dup_err, game_won, game_over}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Clean 1,2,3,4 then ENTER
    press(1); press(2); press(3); press(4);
    press(11);
    check_val("t1.guess", 32'(guess), 32'h1234);

    // Duplicate then CLEAR
    press(5); press(5);
    press(10);

    // Bouncing key accepted once
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      key_digit[7] = (s % 2 == 0);
      repeat (2) @(negedge clk);
    end
    key_digit[7] = 1'b1;
    repeat (HOLD) @(negedge clk);
    key_digit[7] = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_key(7);
    check_all("bounce");

    // Chord of 3 and 7 is ignored
    @(negedge clk);
    drive_keys(12'h088);
    repeat (HOLD) @(negedge clk);
    drive_keys('0);
    repeat (HOLD) @(negedge clk);
    check_all("chord");

    // Winning guess, digits ignored while won, CLEAR restarts
    press(10);
    press(1); press(2); press(3); press(4);
    win_next = 1'b1;
    press(11);
    win_next = 1'b0;
    press(6);
    press(10);

    // Ten losing guesses end the game
    for (int g = 0; g < MAXA; g++) begin
      for (int k = 0; k < 4; k++) press((g + k) % 10);
      press(11);
    end
    check_val("lost.over", 32'(game_over), 32'd1);
    check_val("lost.won",  32'(game_won),  32'd0);
    press(10);

    // Random key traffic
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 99);
      if (r < 70) idx = $urandom_range(0, 9);
      else if (r < 80) idx = 10;
      else idx = 11;
      win_next = ($urandom_range(0, 4) == 0);
      press(idx);
    end
    win_next = 1'b0;
    check_val("gv.double", 32'(gv_double), 32'd0);

    // Reset during WAIT_RESULT with a digit held
    if (m_state != M_ENTRY) press(10);
    press(10);
    press(9); press(8); press(7); press(6);
    @(negedge clk);
    drive_keys(12'h800);
    n = 0;
    while (!guess_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("wr.gv_seen", 32'(n < 40), 32'd1);
    drive_keys(12'h020);
    rst = 1'b0;
    #1;
    check_val("wr.buf",   32'(entry_buf),   32'hFFFF);
    check_val("wr.guess", 32'(guess),       32'hFFFF);
    check_val("wr.cnt",   32'(digit_count), 32'd0);
    check_val("wr.att",   32'(attempts),    32'd0);
    check_val("wr.flags", 32'({guess_valid, dup_err, game_won, game_over}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (entry_buf == 16'hFFFF && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("wr.latency", 32'(n), 32'(DEB + 4));
    check_val("wr.held",    32'(entry_buf), 32'hFFF5);
    @(negedge clk);
    drive_keys('0);
    repeat (HOLD) @(negedge clk);
    mq.delete();
    mq.push_back(5);
    m_att   = 0;
    m_state = M_ENTRY;
    m_guess = 16'hFFFF;
    dup_seen = 0; exp_dup = 0;
    gv_seen  = 0; exp_gv  = 0;
    check_all("post_rst");
    press(5);
    press(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
